// File: rtl/kyber_pkg.sv
// Shared Kyber NTT constants, FSM state type and index widths.
// Used by the NTT sequencer, its address generator and the bench.
package kyber_pkg;

  localparam int KYBER_N    = 256;
  localparam int KYBER_Q    = 3329;
  localparam int NTT_LAYERS = 7;

  localparam logic [11:0] INTT_F = 12'd1441;

  typedef logic [7:0] coef_idx_t;
  typedef logic [6:0] tw_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SCALE,
    DRAIN,
    FIN
  } ntt_state_e;

endpackage

// File: rtl/ntt_ctrl_if.sv
// Issue bus between the NTT sequencer and the butterfly datapath.
// One bf_ready handshake serves both butterfly and scaling issues.
interface ntt_ctrl_if;
  import kyber_pkg::*;

  logic      bf_valid;
  logic      bf_ready;
  logic      bf_inv;
  coef_idx_t bf_addr_a;
  coef_idx_t bf_addr_b;
  tw_idx_t   tw_addr;
  logic      sc_valid;
  coef_idx_t sc_addr;

  modport master (
    output bf_valid,
    input  bf_ready,
    output bf_inv,
    output bf_addr_a,
    output bf_addr_b,
    output tw_addr,
    output sc_valid,
    output sc_addr
  );

  modport slave (
    input  bf_valid,
    output bf_ready,
    input  bf_inv,
    input  bf_addr_a,
    input  bf_addr_b,
    input  tw_addr,
    input  sc_valid,
    input  sc_addr
  );

endinterface

// File: rtl/ntt_addr_gen.sv
// Maps (layer, butterfly, direction) to coefficient pair and zeta index.
// Pure combinational; len = 2^L with L = 7-s forward, 1+s inverse.
module ntt_addr_gen
  import kyber_pkg::*;
(
  input  logic [2:0] s,
  input  logic [6:0] b,
  input  logic       inv,
  output coef_idx_t  addr_a,
  output coef_idx_t  addr_b,
  output tw_idx_t    tw_addr
);

  logic [2:0] l;
  logic [2:0] sh;
  coef_idx_t  b8;
  coef_idx_t  mask;
  coef_idx_t  a;
  logic [6:0] g;

  // Insert a zero at bit L of b; the high part of b is the group.
  always_comb begin
    l    = inv ? 3'(s + 3'd1) : 3'(3'd7 - s);
    sh   = inv ? s : 3'(3'd6 - s);
    b8   = {1'b0, b};
    mask = 8'((8'd1 << l) - 8'd1);
    a    = ((b8 & ~mask) << 1) | (b8 & mask);
    g    = b >> l;
    addr_a = a;
    addr_b = a | (8'd1 << l);
    // 128>>L == 64>>(L-1) and (256>>L)-1 == 127>>(L-1), kept in 7 bits
    if (inv) begin
      tw_addr = 7'((7'h7f >> sh) - g);
    end else begin
      tw_addr = 7'((7'h40 >> sh) + g);
    end
  end

endmodule

// File: rtl/ntt_ctrl.sv
// Kyber NTT/INTT sequencer: butterfly issue, scaling pass, drain, done.
// All bus outputs are registered; a stalled issue holds everything.
module ntt_ctrl
  import kyber_pkg::*;
#(
  parameter int BF_LATENCY = 4,
  parameter int N_LOG2     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  ntt_ctrl_if.master bus
);

  localparam logic [6:0] B_LAST = 7'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [2:0] S_LAST = 3'(N_LOG2 - 2);
  localparam logic [7:0] SC_LAST = 8'(KYBER_N - 1);
  localparam logic [7:0] DRAIN_LD = 8'(BF_LATENCY);

  ntt_state_e state;
  logic [2:0] s;
  logic [6:0] b;
  logic [7:0] drain;

  logic [2:0] gs;
  logic [6:0] gb;
  logic       gm;
  logic       last;
  coef_idx_t  ga;
  coef_idx_t  gbb;
  tw_idx_t    gk;

  // Address of the issue that follows: first issue in IDLE, else b+1.
  always_comb begin
    gs = 3'd0;
    gb = 7'd0;
    gm = mode;
    if (state != IDLE) begin
      gm = bus.bf_inv;
      gb = 7'(b + 7'd1);
      gs = (b == B_LAST) ? 3'(s + 3'd1) : s;
    end
    last = (s == S_LAST) && (b == B_LAST);
  end

  ntt_addr_gen u_gen (
    .s       (gs),
    .b       (gb),
    .inv     (gm),
    .addr_a  (ga),
    .addr_b  (gbb),
    .tw_addr (gk)
  );

  // Main FSM with counters and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      s             <= 3'd0;
      b             <= 7'd0;
      drain         <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.bf_valid  <= 1'b0;
      bus.sc_valid  <= 1'b0;
      bus.bf_inv    <= 1'b0;
      bus.bf_addr_a <= '0;
      bus.bf_addr_b <= '0;
      bus.tw_addr   <= '0;
      bus.sc_addr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            s             <= 3'd0;
            b             <= 7'd0;
            busy          <= 1'b1;
            bus.bf_valid  <= 1'b1;
            bus.bf_inv    <= mode;
            bus.bf_addr_a <= ga;
            bus.bf_addr_b <= gbb;
            bus.tw_addr   <= gk;
          end
        end
        RUN: begin
          if (bus.bf_ready) begin
            if (last) begin
              bus.bf_valid <= 1'b0;
              s            <= 3'd0;
              b            <= 7'd0;
              if (bus.bf_inv) begin
                state        <= SCALE;
                bus.sc_valid <= 1'b1;
                bus.sc_addr  <= '0;
              end else begin
                state <= DRAIN;
                drain <= DRAIN_LD;
              end
            end else begin
              s             <= gs;
              b             <= gb;
              bus.bf_addr_a <= ga;
              bus.bf_addr_b <= gbb;
              bus.tw_addr   <= gk;
            end
          end
        end
        SCALE: begin
          if (bus.bf_ready) begin
            if (bus.sc_addr == SC_LAST) begin
              bus.sc_valid <= 1'b0;
              state        <= DRAIN;
              drain        <= DRAIN_LD;
            end else begin
              bus.sc_addr <= bus.sc_addr + 8'd1;
            end
          end
        end
        DRAIN: begin
          drain <= drain - 8'd1;
          if (drain <= 8'd1) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: Kyber loop reference model, random back-pressure,
// ignored start, mid-run reset.
module tb_ntt_ctrl;
  import kyber_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic busy;
  logic done;

  int total = 0;
  int bad = 0;

  ntt_ctrl_if bus ();

  ntt_ctrl #(
    .BF_LATENCY (LAT),
    .N_LOG2     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int k;
  } iss_t;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {bus.bf_valid, bus.sc_valid, bus.bf_inv, bus.bf_addr_a,
            bus.bf_addr_b, bus.tw_addr, bus.sc_addr, busy, done};
  endfunction

  task automatic run_xform(input bit m, input bit rnd,
                           input int poke_at, input int rst_at);
    iss_t q[$];
    iss_t e;
    int k;
    int nbf = 0;
    int nsc = 0;
    int ndone = 0;
    int done_cyc = -1;
    int last_cyc = -1;
    int bcnt = 0;
    int overlap = 0;
    int inv_err = 0;
    bit stalled = 0;
    bit rdy;
    logic [35:0] snap = '0;
    logic [35:0] cur;

    if (m == 0) begin
      k = 1;
      for (int len = 128; len >= 2; len >>= 1)
        for (int st = 0; st < KYBER_N; st += 2 * len) begin
          for (int j = st; j < st + len; j++) q.push_back('{j, j + len, k});
          k++;
        end
    end else begin
      k = 127;
      for (int len = 2; len <= 128; len <<= 1)
        for (int st = 0; st < KYBER_N; st += 2 * len) begin
          for (int j = st; j < st + len; j++) q.push_back('{j, j + len, k});
          k--;
        end
    end

    @(negedge clk);
    start = 1'b1;
    mode = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 1'($urandom);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      cur = outs();
      if (stalled) chk("stall_hold", 64'(cur), 64'(snap));
      if (cyc == 0) begin
        chk("first_valid", 64'(bus.bf_valid), 64'(1));
        chk("first_busy", 64'(busy), 64'(1));
      end
      if (busy) bcnt++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.bf_valid && bus.sc_valid) overlap++;
      if (bus.bf_valid && bus.bf_inv !== m) inv_err++;
      if (done_cyc >= 0 && cyc >= done_cyc + 10) break;

      if (rst_at >= 0 && nbf == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 64'(outs()), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_hold", 64'(outs()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end

      start = (cyc == poke_at);
      if (cyc == poke_at) mode = ~m;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bf_ready = rdy;

      if (bus.bf_valid && rdy) begin
        if (q.size() == 0) begin
          chk("extra_issue", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("issue_a", 64'(bus.bf_addr_a), 64'(e.a));
          chk("issue_b", 64'(bus.bf_addr_b), 64'(e.b));
          chk("issue_k", 64'(bus.tw_addr), 64'(e.k));
        end
        nbf++;
        last_cyc = cyc;
      end
      if (bus.sc_valid && rdy) begin
        chk("sc_addr", 64'(bus.sc_addr), 64'(nsc));
        nsc++;
        last_cyc = cyc;
      end
      stalled = (bus.bf_valid || bus.sc_valid) && !rdy;
      snap = cur;
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    chk("n_bf", 64'(nbf), 64'(896));
    chk("n_sc", 64'(nsc), 64'(m ? KYBER_N : 0));
    chk("q_left", 64'(q.size()), 64'(0));
    chk("done_cnt", 64'(ndone), 64'(1));
    chk("done_gap", 64'(done_cyc - last_cyc), 64'(LAT + 1));
    chk("busy_len", 64'(bcnt), 64'(done_cyc + 1));
    if (!rnd)
      chk("busy_abs", 64'(bcnt), 64'(896 + (m ? KYBER_N : 0) + LAT + 1));
    chk("overlap", 64'(overlap), 64'(0));
    chk("inv_latch", 64'(inv_err), 64'(0));
  endtask

  initial begin
    bus.bf_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 64'(outs()), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_outs", 64'(outs()), 64'(0));

    run_xform(1'b0, 1'b0, -1, -1);
    run_xform(1'b1, 1'b0, -1, -1);
    run_xform(1'b0, 1'b1, -1, -1);
    run_xform(1'b1, 1'b1, -1, -1);
    run_xform(1'b0, 1'b0, 100, -1);
    run_xform(1'b1, 1'b0, 500, -1);
    run_xform(1'b0, 1'b1, -1, 300);
    run_xform(1'b0, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
